pulse_train_gen: RTL and testbench
==================================

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter: CNT_W, default 16, width of the pulse-count input and the remaining-count output.
REQ-002 Parameter: GAP_W, default 8, width of the inter-pulse gap input.
REQ-003 Port: clock  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  system reset; synchronous, active-high.
REQ-005 Port: data_in  input  CNT_W  number of pulses to emit; sampled only when a load is accepted.
REQ-006 Port: gap_in  input  GAP_W  idle cycles between consecutive pulses; sampled only when a load is accepted.
REQ-007 Port: load  input  1  start request; level-sampled each edge.
REQ-008 Port: abort  input  1  cancel request; level-sampled each edge.
REQ-009 Port: pulse_out  output  1  registered; one-cycle-high output pulse per emitted count.
REQ-010 Port: busy  output  1  registered; high while a train is in progress.
REQ-011 Port: done  output  1  registered; one-cycle-high completion strobe.
REQ-012 Port: remaining  output  CNT_W  registered; pulses still to be emitted.

Function
REQ-013 The FSM SHALL have four states: IDLE, PULSE, GAP and DONE.
REQ-014 All outputs SHALL be registered and SHALL be decoded from the state and counters: pulse_out = (state==PULSE), busy = (state==PULSE or GAP), done = (state==DONE).
REQ-015 IDLE, load=1, abort=0, data_in!=0: capture remaining<=data_in and gap register<=gap_in, then go to PULSE, so that pulse_out is high in the cycle after the load edge (latency 1).
REQ-016 IDLE, load=1, abort=0, data_in==0: go directly to DONE with remaining=0; no pulse is emitted.
REQ-017 Leaving PULSE: remaining SHALL decrement by 1 (no wrap; remaining is never 0 in PULSE).
REQ-018 Leaving PULSE with post-decrement remaining==0: go to DONE; no trailing gap is inserted.
REQ-019 Leaving PULSE with remaining!=0 and gap==0: stay in PULSE, so pulse_out is high continuously for N cycles.
REQ-020 Leaving PULSE with remaining!=0 and gap==G>0: go to GAP and load the gap counter with G.
REQ-021 In GAP, the gap counter SHALL decrement each cycle and SHALL return to PULSE after exactly G cycles, so rising edges of pulse_out are G+1 cycles apart.
REQ-022 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-023 A load seen in PULSE, GAP or DONE SHALL be ignored; it is not queued, and captured values do not change.
REQ-024 abort=1 in PULSE or GAP: go to IDLE at the next edge, clear remaining to 0, and raise no done.
REQ-025 abort=1 in IDLE: abort wins over a simultaneous load, and the state stays IDLE.
REQ-026 abort=1 in DONE: the done cycle still completes normally.
REQ-027 data_in=all-ones SHALL produce exactly 2^CNT_W-1 pulses, with no overflow or wrap of remaining.
REQ-028 data_in and gap_in changing after an accepted load SHALL have no effect on the train in progress.

Reset
REQ-029 With reset=1 at an edge, the next state SHALL be IDLE with pulse_out=0, busy=0, done=0, remaining=0 and the gap counter=0, regardless of load or abort.
REQ-030 Reset SHALL override every other input, including mid-train; no done is emitted for the interrupted train.
REQ-031 After reset deasserts, a load SHALL be accepted on the first edge at which reset=0.

Verification
REQ-032 Load with data_in=3, gap_in=0 -> pulse_out high for 3 consecutive cycles starting at load+1; remaining reads 3,2,1 during the pulses; done high at load+4; busy low at load+4.
REQ-033 Load with data_in=2, gap_in=2 -> pulses at load+1 and load+4, pulse_out low at load+2 and load+3, done at load+5.
REQ-034 Load with data_in=0 -> no pulse; done at load+1; busy stays 0.
REQ-035 Load with data_in=5, gap_in=1, then abort during the 2nd gap cycle -> IDLE at the next edge; remaining=0; no done; total pulses seen = 2.
REQ-036 Load with data_in=4, gap_in=3, then a second load with data_in=9 while busy -> exactly 4 pulses emitted and one done; the second load is ignored.
REQ-037 Reset asserted for 1 cycle mid-train -> all outputs 0 at the next cycle; a fresh load with data_in=1 -> one pulse, then done.

Source files
------------

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - Pulse train generator: N one-cycle pulses separated by G idle cycles
module pulse_train_gen #(
    parameter int CNT_W = 16,
    parameter int GAP_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] data_in,
    input  logic [GAP_W-1:0] gap_in,
    input  logic             load,
    input  logic             abort,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] remaining_next;
    logic [GAP_W-1:0] gap_reg;
    logic [GAP_W-1:0] gap_reg_next;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_cnt_next;

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        gap_reg_next   = gap_reg;
        gap_cnt_next   = gap_cnt;
        case (state)
            IDLE: begin
                if (load && !abort) begin
                    gap_reg_next = gap_in;
                    if (data_in != '0) begin
                        remaining_next = data_in;
                        state_next     = PULSE;
                    end else begin
                        remaining_next = '0;
                        state_next     = DONE;
                    end
                end
            end
            PULSE: begin
                if (abort) begin
                    state_next     = IDLE;
                    remaining_next = '0;
                    gap_cnt_next   = '0;
                end else begin
                    // remaining counts the pulse currently on the output, so it is never 0 here
                    remaining_next = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_next = DONE;
                    end else if (gap_reg != '0) begin
                        state_next   = GAP;
                        gap_cnt_next = gap_reg;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_next     = IDLE;
                    remaining_next = '0;
                    gap_cnt_next   = '0;
                end else begin
                    gap_cnt_next = gap_cnt - GAP_W'(1);
                    if (gap_cnt == GAP_W'(1)) begin
                        state_next = PULSE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            gap_reg   <= '0;
            gap_cnt   <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            gap_reg   <= gap_reg_next;
            gap_cnt   <= gap_cnt_next;
            pulse_out <= (state_next == PULSE);
            busy      <= (state_next == PULSE) || (state_next == GAP);
            done      <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - Self-checking bench for pulse_train_gen against a schedule-based model
module tb_pulse_train_gen;

    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [CNT_W-1:0] data_in;
    logic [GAP_W-1:0] gap_in;
    logic             load;
    logic             abort;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

    int tests    = 0;
    int failures = 0;
    int cyc      = 0;
    int pulses_seen = 0;
    int dones_seen  = 0;

    // Model: a train is a schedule in time t (cycles since the accepting edge)
    int m_active = 0;
    int m_t = 0;
    int m_n = 0;
    int m_g = 0;

    pulse_train_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .data_in   (data_in),
        .gap_in    (gap_in),
        .load      (load),
        .abort     (abort),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clock = ~clock;

    function automatic int m_last();
        return (m_n == 0) ? 0 : 1 + (m_n - 1) * (m_g + 1);
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_active = 0;
        end else if (m_active != 0) begin
            if (m_t <= m_last() && abort) m_active = 0;
            else if (m_t == m_last() + 1) m_active = 0;
            else m_t++;
        end else if (load && !abort) begin
            m_active = 1;
            m_n = int'(data_in);
            m_g = int'(gap_in);
            m_t = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        int last;
        logic e_pulse, e_busy, e_done;
        int e_rem;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        cyc++;
        e_pulse = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_rem = 0;
        if (m_active != 0) begin
            last    = m_last();
            e_busy  = (m_t <= last);
            e_pulse = e_busy && (((m_t - 1) % (m_g + 1)) == 0);
            e_done  = (m_t == last + 1);
            e_rem   = e_busy ? m_n - ((m_t - 1 + m_g) / (m_g + 1)) : 0;
        end
        check("pulse_out", 32'(pulse_out), 32'(e_pulse));
        check("busy",      32'(busy),      32'(e_busy));
        check("done",      32'(done),      32'(e_done));
        check("remaining", 32'(remaining), 32'(e_rem));
        if (pulse_out) pulses_seen++;
        if (done) dones_seen++;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; load = 1'b0; abort = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b1; abort = 1'b0; data_in = 8'd7; gap_in = 4'd1;
        step();
        step();
        // load accepted on the first edge after reset deasserts
        idle_inputs(); load = 1'b1; data_in = 8'd3; gap_in = 4'd0;
        step();
        idle_inputs(); data_in = 8'd99; gap_in = 4'd5;
        repeat (5) step();

        // data 2, gap 2
        load = 1'b1; data_in = 8'd2; gap_in = 4'd2;
        step();
        idle_inputs();
        repeat (6) step();

        // data 0: done only
        pulses_seen = 0; dones_seen = 0;
        load = 1'b1; data_in = 8'd0; gap_in = 4'd3;
        step();
        idle_inputs();
        repeat (3) step();
        check("zero_pulses", 32'(pulses_seen), 32'd0);
        check("zero_dones",  32'(dones_seen),  32'd1);

        // data 5, gap 1, abort during second gap cycle
        pulses_seen = 0; dones_seen = 0;
        load = 1'b1; data_in = 8'd5; gap_in = 4'd1;
        step();
        idle_inputs();
        repeat (3) step();
        abort = 1'b1;
        step();
        idle_inputs();
        repeat (4) step();
        check("abort_pulses", 32'(pulses_seen), 32'd2);
        check("abort_dones",  32'(dones_seen),  32'd0);

        // abort wins over load in IDLE
        load = 1'b1; abort = 1'b1; data_in = 8'd4;
        step();
        idle_inputs();
        step();

        // second load while busy is ignored
        pulses_seen = 0; dones_seen = 0;
        load = 1'b1; data_in = 8'd4; gap_in = 4'd3;
        step();
        data_in = 8'd9; gap_in = 4'd0;
        repeat (6) step();
        idle_inputs();
        repeat (12) step();
        check("reload_pulses", 32'(pulses_seen), 32'd4);
        check("reload_dones",  32'(dones_seen),  32'd1);

        // load and abort during DONE
        load = 1'b1; data_in = 8'd1; gap_in = 4'd0;
        step();
        step();
        abort = 1'b1;
        step();
        idle_inputs();
        step();

        // reset mid-train, then a single-pulse train
        load = 1'b1; data_in = 8'd6; gap_in = 4'd1;
        step();
        idle_inputs();
        repeat (3) step();
        reset = 1'b1;
        step();
        pulses_seen = 0; dones_seen = 0;
        idle_inputs(); load = 1'b1; data_in = 8'd1;
        step();
        idle_inputs();
        repeat (3) step();
        check("post_reset_pulses", 32'(pulses_seen), 32'd1);
        check("post_reset_dones",  32'(dones_seen),  32'd1);

        // all-ones count: full 2^CNT_W-1 pulses
        pulses_seen = 0; dones_seen = 0;
        load = 1'b1; data_in = '1; gap_in = 4'd0;
        step();
        idle_inputs();
        repeat (257) step();
        check("allones_pulses", 32'(pulses_seen), 32'd255);
        check("allones_dones",  32'(dones_seen),  32'd1);

        // randomized traffic, including input changes mid-train
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 199) == 0);
            load    = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 39) == 0);
            data_in = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 7));
            gap_in  = GAP_W'($urandom_range(0, 15) < 12 ? $urandom_range(0, 3) : $urandom);
            step();
        end
        idle_inputs();
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
